// File: rtl/brute_force_matcher.sv
// brute_force_matcher
//   Brute-force search for every occurrence of a PAT_LEN-symbol pattern (pattern ROM)
//   in a text ROM, starting at a programmable text position. Overlapping matches are
//   counted. Mode 0 counts all matches; mode 1 stops at the first one.
// Ports
//   clk, rst         : rising-edge clock, asynchronous active-low reset
//   start/mode/start_addr : search request, sampled only in IDLE
//   pat_addr/pat_data : pattern ROM interface (registered address, 1-cycle data)
//   txt_addr/txt_data : text ROM interface (registered address, 1-cycle data)
//   busy, done       : search in progress / 1-cycle completion pulse
//   found, count, first_pos : results, held until the next accepted start
module brute_force_matcher #(
  parameter int DATA_W  = 8,
  parameter int PAT_LEN = 4,
  parameter int PAT_AW  = 3,
  parameter int TXT_AW  = 14,
  parameter int TXT_LEN = 11064,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [TXT_AW-1:0] start_addr,
  output logic [PAT_AW-1:0] pat_addr,
  input  logic [DATA_W-1:0] pat_data,
  output logic [TXT_AW-1:0] txt_addr,
  input  logic [DATA_W-1:0] txt_data,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [CNT_W-1:0]  count,
  output logic [TXT_AW-1:0] first_pos
);

  localparam logic [TXT_AW-1:0] LAST  = TXT_AW'(TXT_LEN - PAT_LEN);
  localparam logic [PAT_AW-1:0] J_END = PAT_AW'(PAT_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_COMPARE, S_DONE} state_t;

  state_t              r_state, w_state_n;
  logic [TXT_AW-1:0]   r_pos, w_pos_n;
  logic [PAT_AW-1:0]   r_j, w_j_n;
  logic                r_mode, w_mode_n;
  logic [CNT_W-1:0]    r_count, w_count_n;
  logic                r_found, w_found_n;
  logic [TXT_AW-1:0]   r_first, w_first_n;
  logic [TXT_AW-1:0]   r_txt_addr, w_txt_addr_n;
  logic [PAT_AW-1:0]   r_pat_addr, w_pat_addr_n;
  logic                w_adv;
  logic [TXT_AW-1:0]   w_pos_inc;
  logic [PAT_AW-1:0]   w_j_inc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pos      <= '0;
      r_j        <= '0;
      r_mode     <= 1'b0;
      r_count    <= '0;
      r_found    <= 1'b0;
      r_first    <= '0;
      r_txt_addr <= '0;
      r_pat_addr <= '0;
    end else begin
      r_pos      <= w_pos_n;
      r_j        <= w_j_n;
      r_mode     <= w_mode_n;
      r_count    <= w_count_n;
      r_found    <= w_found_n;
      r_first    <= w_first_n;
      r_txt_addr <= w_txt_addr_n;
      r_pat_addr <= w_pat_addr_n;
    end
  end

  // ROM addresses are loaded on the edge entering FETCH so the ROMs can latch
  // them on the FETCH->COMPARE edge, giving two cycles per compared symbol.
  always_comb begin
    w_state_n    = r_state;
    w_pos_n      = r_pos;
    w_j_n        = r_j;
    w_mode_n     = r_mode;
    w_count_n    = r_count;
    w_found_n    = r_found;
    w_first_n    = r_first;
    w_txt_addr_n = r_txt_addr;
    w_pat_addr_n = r_pat_addr;
    w_adv        = 1'b0;
    w_pos_inc    = r_pos + TXT_AW'(1);
    w_j_inc      = r_j + PAT_AW'(1);
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_count_n = '0;
          w_found_n = 1'b0;
          w_first_n = '0;
          if (start_addr <= LAST) begin
            w_pos_n      = start_addr;
            w_j_n        = '0;
            w_mode_n     = mode;
            w_txt_addr_n = start_addr;
            w_pat_addr_n = '0;
            w_state_n    = S_FETCH;
          end else begin
            w_state_n = S_DONE;
          end
        end
      end
      S_FETCH: w_state_n = S_COMPARE;
      S_COMPARE: begin
        if (txt_data != pat_data) begin
          w_adv = 1'b1;
        end else if (r_j != J_END) begin
          w_j_n        = w_j_inc;
          w_txt_addr_n = r_pos + TXT_AW'(w_j_inc);
          w_pat_addr_n = w_j_inc;
          w_state_n    = S_FETCH;
        end else begin
          if (r_count != '1) w_count_n = r_count + CNT_W'(1);
          if (!r_found) begin
            w_found_n = 1'b1;
            w_first_n = r_pos;
          end
          if (r_mode) w_state_n = S_DONE;
          else        w_adv     = 1'b1;
        end
        if (w_adv) begin
          w_j_n   = '0;
          w_pos_n = w_pos_inc;
          if (w_pos_inc > LAST) begin
            w_state_n = S_DONE;
          end else begin
            w_txt_addr_n = w_pos_inc;
            w_pat_addr_n = '0;
            w_state_n    = S_FETCH;
          end
        end
      end
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  assign busy      = (r_state == S_FETCH) || (r_state == S_COMPARE);
  assign done      = (r_state == S_DONE);
  assign found     = r_found;
  assign count     = r_count;
  assign first_pos = r_first;
  assign txt_addr  = r_txt_addr;
  assign pat_addr  = r_pat_addr;

endmodule

// File: tb/tb_brute_force_matcher.sv
// Bench for brute_force_matcher: two instances (CNT_W=4 and CNT_W=2) share stimulus
// and ROM contents; a loop-based search model predicts results and done timing.
module tb_brute_force_matcher;

  localparam int DW = 8, PL = 3, PAW = 2, TAW = 4, TL = 8;
  localparam int LASTP = TL - PL;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, md = 1'b0;
  logic [TAW-1:0] sa = '0;

  logic [DW-1:0] txt_mem [0:15];
  logic [DW-1:0] pat_mem [0:3];

  logic [PAW-1:0] pat_addr_a, pat_addr_b;
  logic [TAW-1:0] txt_addr_a, txt_addr_b, first_a, first_b;
  logic [DW-1:0]  pat_q_a, pat_q_b, txt_q_a, txt_q_b;
  logic busy_a, busy_b, done_a, done_b, found_a, found_b;
  logic [3:0] count_a;
  logic [1:0] count_b;

  brute_force_matcher #(.DATA_W(DW), .PAT_LEN(PL), .PAT_AW(PAW), .TXT_AW(TAW),
                        .TXT_LEN(TL), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst_n), .start(start), .mode(md), .start_addr(sa),
    .pat_addr(pat_addr_a), .pat_data(pat_q_a), .txt_addr(txt_addr_a), .txt_data(txt_q_a),
    .busy(busy_a), .done(done_a), .found(found_a), .count(count_a), .first_pos(first_a));

  brute_force_matcher #(.DATA_W(DW), .PAT_LEN(PL), .PAT_AW(PAW), .TXT_AW(TAW),
                        .TXT_LEN(TL), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst_n), .start(start), .mode(md), .start_addr(sa),
    .pat_addr(pat_addr_b), .pat_data(pat_q_b), .txt_addr(txt_addr_b), .txt_data(txt_q_b),
    .busy(busy_b), .done(done_b), .found(found_b), .count(count_b), .first_pos(first_b));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    txt_q_a <= txt_mem[txt_addr_a];
    pat_q_a <= pat_mem[pat_addr_a];
    txt_q_b <= txt_mem[txt_addr_b];
    pat_q_b <= pat_mem[pat_addr_b];
  end

  // expectations published by the driver
  int exp_done_cyc, exp_cnt, exp_first, exp_steps;
  bit exp_found;
  int pin_cnt, pin_done_cyc, pin_first;  // -1 = no hand-computed pin
  int arm_id = 0;

  // owned by the compare process
  int fin_id = 0;
  int checks = 0, failures = 0;
  int cyc = 0;
  int hold_cnt_a = 0, hold_cnt_b = 0, hold_first = 0;
  bit hold_found = 1'b0;
  logic [TAW-1:0] saved_taddr;

  function automatic int sat(input int c, input int w);
    return (c > (1 << w) - 1) ? (1 << w) - 1 : c;
  endfunction

  // Search model: walk positions, compare symbols until a mismatch or a full match.
  task automatic model(input int s, input bit m, output int steps, output int cnt,
                       output bit fnd, output int fp);
    bit stop;
    steps = 0; cnt = 0; fnd = 1'b0; fp = 0; stop = 1'b0;
    for (int p = s; p <= LASTP && !stop; p++) begin
      for (int j = 0; j < PL; j++) begin
        steps++;
        if (txt_mem[p + j] != pat_mem[j]) break;
        if (j == PL - 1) begin
          cnt++;
          if (!fnd) begin fnd = 1'b1; fp = p; end
          if (m) stop = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", busy_a | busy_b, 0);
      chk("rst_done", done_a | done_b, 0);
      chk("rst_count", count_a + count_b, 0);
      chk("rst_found", found_a | found_b, 0);
      chk("rst_first", first_a, 0);
      chk("rst_addr", txt_addr_a + pat_addr_a, 0);
      hold_cnt_a = 0; hold_cnt_b = 0; hold_first = 0; hold_found = 1'b0;
      fin_id = arm_id;
      cyc = 0;
    end else if (fin_id != arm_id) begin
      if (cyc == 0) saved_taddr = txt_addr_a;
      chk("busy_a", busy_a, (cyc >= 1 && cyc < exp_done_cyc) ? 1 : 0);
      chk("busy_b", busy_b, (cyc >= 1 && cyc < exp_done_cyc) ? 1 : 0);
      chk("done_a", done_a, (cyc == exp_done_cyc) ? 1 : 0);
      chk("done_b", done_b, (cyc == exp_done_cyc) ? 1 : 0);
      if (cyc == exp_done_cyc) begin
        chk("count_a", count_a, sat(exp_cnt, 4));
        chk("count_b", count_b, sat(exp_cnt, 2));
        chk("found", found_a, exp_found);
        chk("first_pos", first_a, exp_first);
        if (exp_steps == 0) chk("no_rom_access", txt_addr_a, saved_taddr);
        if (pin_cnt >= 0) begin
          chk("pin_count", count_a, pin_cnt);
          chk("pin_model_count", exp_cnt, pin_cnt);
        end
        if (pin_done_cyc >= 0) chk("pin_done_cyc", exp_done_cyc, pin_done_cyc);
        if (pin_first >= 0) chk("pin_first", first_a, pin_first);
        hold_cnt_a = count_a; hold_cnt_b = count_b;
        hold_found = found_a; hold_first = first_a;
        fin_id = arm_id;
        cyc = 0;
      end else begin
        cyc++;
      end
    end else begin
      chk("idle_busy", busy_a | busy_b, 0);
      chk("idle_done", done_a | done_b, 0);
      chk("hold_count_a", count_a, hold_cnt_a);
      chk("hold_count_b", count_b, hold_cnt_b);
      chk("hold_found", found_a, hold_found);
      chk("hold_first", first_a, hold_first);
      cyc = 0;
    end
  end

  task automatic load(input string t, input string p);
    for (int i = 0; i < 16; i++) txt_mem[i] = (i < TL) ? t[i] : 8'h00;
    for (int i = 0; i < 4; i++)  pat_mem[i] = (i < PL) ? p[i] : 8'h00;
  endtask

  task automatic launch(input int s, input bit m, input int pc, input int pd, input int pf);
    int st, cn, fp;
    bit fd;
    @(posedge clk); #1;
    model(s, m, st, cn, fd, fp);
    exp_steps = st; exp_cnt = cn; exp_found = fd; exp_first = fp;
    exp_done_cyc = 2 * st + 1;
    pin_cnt = pc; pin_done_cyc = pd; pin_first = pf;
    start = 1'b1; sa = TAW'(s); md = m;
    arm_id++;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_wait();
    for (int k = 0; k < 200 && fin_id != arm_id; k++) @(posedge clk);
    if (fin_id != arm_id) begin
      $display("FAIL timeout: done never observed, checks=%0d", checks);
      $fatal(1, "bench timeout");
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic run(input int s, input bit m, input int pc, input int pd, input int pf);
    launch(s, m, pc, pd, pf);
    finish_wait();
  endtask

  initial begin
    load("abababax", "aba");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run(0, 1'b0, 3, 25, 0);     // all overlapping matches
    run(1, 1'b1, 1, 9, 2);      // stop at first match
    run(5, 1'b0, 0, 3, -1);     // start at LAST
    run(6, 1'b0, 0, 1, -1);     // beyond LAST: immediate done
    run(7, 1'b1, -1, -1, -1);
    load("xxxxxxxx", "aba");
    run(0, 1'b0, 0, 13, -1);
    load("aaaaaaaa", "aaa");
    run(0, 1'b0, 6, 37, 0);     // dut_b saturates at 3
    run(4, 1'b1, 1, 7, 4);
    load("abababax", "aba");
    launch(0, 1'b0, -1, -1, -1);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    launch(0, 1'b0, 3, 25, 0);
    repeat (4) @(posedge clk);
    #1 start = 1'b1; sa = 4'd3; md = 1'b1;   // must be ignored while busy
    @(posedge clk); #1 start = 1'b0;
    finish_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
